// File: rtl/usr_shift_engine.sv
// Universal shift register: load/clear/shift/rotate with a command handshake.
// Rotate opcodes are built only when USR_SHIFT_ROTATE_EN is defined.
module usr_shift_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] load_data,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LD  = 3'b001;
  localparam logic [2:0] OP_SHR = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_CLR = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;
  localparam logic [2:0] OP_ROL = 3'b110;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO = '0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] step;
  logic [CNT_W-1:0] rem, rem_n;
  logic [2:0]       op_r, op_n;
  logic             done_n;
  logic             is_ld, is_clr, is_sh, is_rot;
  logic             multi;

  assign busy      = (state == SHIFT);
  assign cmd_ready = ~busy;
  assign sout_r    = q[0];
  assign sout_l    = q[WIDTH-1];

  assign is_ld  = (cmd_op == OP_LD);
  assign is_clr = (cmd_op == OP_CLR);
  assign is_sh  = (cmd_op == OP_SHR) | (cmd_op == OP_SHL);
`ifdef USR_SHIFT_ROTATE_EN
  assign is_rot = (cmd_op == OP_ROR) | (cmd_op == OP_ROL);
`else
  assign is_rot = 1'b0;
`endif
  assign multi = (is_sh | is_rot) & (cmd_cnt != ZERO);

  // One-bit step of the latched operation
  always_comb begin
    step = q;
    unique case (op_r)
      OP_SHR:  step = {sin_r, q[WIDTH-1:1]};
      OP_SHL:  step = {q[WIDTH-2:0], sin_l};
`ifdef USR_SHIFT_ROTATE_EN
      OP_ROR:  step = {q[0], q[WIDTH-1:1]};
      OP_ROL:  step = {q[WIDTH-2:0], q[WIDTH-1]};
`endif
      default: step = q;
    endcase
  end

  always_comb begin
    state_n = state;
    q_n     = q;
    rem_n   = rem;
    op_n    = op_r;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (multi) begin
            state_n = SHIFT;
            rem_n   = cmd_cnt;
            op_n    = cmd_op;
          end else begin
            done_n = 1'b1;
            unique case (1'b1)
              is_ld:   q_n = load_data;
              is_clr:  q_n = '0;
              default: q_n = q;
            endcase
          end
        end
      end
      SHIFT: begin
        q_n   = step;
        rem_n = rem - ONE;
        if (rem == ONE) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      q     <= '0;
      rem   <= '0;
      op_r  <= OP_NOP;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      q     <= q_n;
      rem   <= rem_n;
      op_r  <= op_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_usr_shift_engine.sv
// Directed + random bench for usr_shift_engine against an arithmetic model.
module tb_usr_shift_engine;

  localparam int W    = 8;
  localparam int TOP  = 2 ** (W - 1);
  localparam int FULL = 2 ** W;
`ifdef USR_SHIFT_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_cnt;
  logic [7:0] load_data;
  logic       sin_r;
  logic       sin_l;
  logic [7:0] q;
  logic       sout_r;
  logic       sout_l;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  int m_q, m_rem, m_op;
  bit m_busy, m_done;

  usr_shift_engine #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt),
    .load_data(load_data),
    .sin_r(sin_r), .sin_l(sin_l),
    .q(q), .sout_r(sout_r), .sout_l(sout_l),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int step(int op, int v, bit sr, bit sl);
    case (op)
      2:       return v / 2 + sr * TOP;
      3:       return (v * 2) % FULL + sl;
      5:       return v / 2 + (v % 2) * TOP;
      6:       return (v * 2) % FULL + v / TOP;
      default: return v;
    endcase
  endfunction

  function automatic bit multi_op(int op);
    return op == 2 || op == 3 || (ROT && (op == 5 || op == 6));
  endfunction

  task automatic check_all(string tag);
    chk({tag, ".q"}, 32'(q), 32'(m_q));
    chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
    chk({tag, ".ready"}, 32'(cmd_ready), 32'(!m_busy));
    chk({tag, ".sout_r"}, 32'(sout_r), 32'(m_q % 2));
    chk({tag, ".sout_l"}, 32'(sout_l), 32'(m_q / TOP));
  endtask

  task automatic tick(string tag);
    int nq, nrem, nop;
    bit nb, nd;
    nq = m_q; nrem = m_rem; nop = m_op; nb = m_busy; nd = 0;
    if (!rst) begin
      nq = 0; nrem = 0; nb = 0;
    end else if (m_busy) begin
      nq = step(m_op, m_q, sin_r, sin_l);
      nrem--;
      if (nrem == 0) begin
        nb = 0; nd = 1;
      end
    end else if (cmd_valid) begin
      if (multi_op(int'(cmd_op)) && cmd_cnt != 0) begin
        nb = 1; nrem = int'(cmd_cnt); nop = int'(cmd_op);
      end else begin
        nd = 1;
        if (cmd_op == 3'd1) nq = int'(load_data);
        if (cmd_op == 3'd4) nq = 0;
      end
    end
    @(posedge clk);
    #1;
    m_q = nq; m_rem = nrem; m_op = nop; m_busy = nb; m_done = nd;
    check_all(tag);
  endtask

  task automatic cmd(logic [2:0] op, logic [3:0] cnt, logic [7:0] d);
    cmd_valid = 1'b1; cmd_op = op; cmd_cnt = cnt; load_data = d;
  endtask

  task automatic idle();
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_cnt = 4'd0; load_data = 8'd0;
  endtask

  initial begin
    rst = 1'b0; sin_r = 1'b0; sin_l = 1'b0;
    idle();
    m_q = 0; m_rem = 0; m_op = 0; m_busy = 0; m_done = 0;
    #2;
    check_all("rst0");

    // LOAD during reset must be ignored
    cmd(3'd1, 4'd0, 8'hFF);
    tick("rst_ld1");
    tick("rst_ld2");
    idle();
    rst = 1'b1;
    tick("rst_rel");
    chk("t1_q", 32'(q), 32'h00);

    cmd(3'd1, 4'd0, 8'hA5);
    tick("t2_ld");
    chk("t2_q", 32'(q), 32'hA5);
    chk("t2_done", 32'(done), 32'h1);
    idle();
    tick("t2_idle");
    chk("t2_done_off", 32'(done), 32'h0);

    sin_r = 1'b1;
    cmd(3'd2, 4'd3, 8'h00);
    tick("t3_acc");
    chk("t3_acc_q", 32'(q), 32'hA5);
    cmd(3'd1, 4'd0, 8'h00);
    tick("t3_s1");
    chk("t3_q1", 32'(q), 32'hD2);
    tick("t3_s2");
    chk("t3_q2", 32'(q), 32'hE9);
    idle();
    tick("t3_s3");
    chk("t3_q3", 32'(q), 32'hF4);
    chk("t3_done", 32'(done), 32'h1);

    sin_l = 1'b0;
    cmd(3'd3, 4'd4, 8'h00);
    tick("t4_acc");
    idle();
    repeat (4) tick("t4_step");
    chk("t4_q", 32'(q), 32'h40);
    chk("t4_done", 32'(done), 32'h1);
    cmd(3'd2, 4'd0, 8'h00);
    tick("t4_cnt0");
    chk("t4_cnt0_q", 32'(q), 32'h40);
    chk("t4_cnt0_done", 32'(done), 32'h1);
    idle();
    tick("t4_idle");

    cmd(3'd1, 4'd0, 8'h81);
    tick("t5_ld");
    cmd(3'd5, 4'd9, 8'h00);
    tick("t5_acc");
    idle();
    if (ROT) begin
      repeat (9) tick("t5_rot");
      chk("t5_q_rot", 32'(q), 32'hC0);
    end else begin
      chk("t5_q_nop", 32'(q), 32'h81);
      chk("t5_busy_nop", 32'(busy), 32'h0);
    end
    chk("t5_done", 32'(done), 32'h1);
    tick("t5_idle");

    cmd(3'd1, 4'd0, 8'h3C);
    tick("t6_ld");
    sin_l = 1'b1;
    cmd(3'd3, 4'd2, 8'h00);
    tick("t6_acc1");
    idle();
    tick("t6_a1");
    tick("t6_a2");
    chk("t6_q_a", 32'(q), 32'hF3);
    sin_l = 1'b0;
    cmd(3'd3, 4'd2, 8'h00);
    tick("t6_acc2");
    idle();
    tick("t6_b1");
    tick("t6_b2");
    chk("t6_q_b", 32'(q), 32'hCC);
    chk("t6_done_b", 32'(done), 32'h1);
    cmd(3'd2, 4'd5, 8'h00);
    tick("t6_acc3");
    idle();
    tick("t6_c1");
    rst = 1'b0;
    #1;
    m_q = 0; m_rem = 0; m_busy = 0; m_done = 0;
    check_all("t6_async");
    chk("t6_async_q", 32'(q), 32'h00);
    repeat (5) tick("t6_inrst");
    rst = 1'b1;
    tick("t6_rel");

    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 59) != 0);
      cmd_valid = $urandom_range(0, 1) == 1;
      cmd_op = 3'($urandom_range(0, 7));
      cmd_cnt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                            : 4'($urandom_range(0, 3));
      load_data = 8'($urandom_range(0, 255));
      sin_r = $urandom_range(0, 1) == 1;
      sin_l = $urandom_range(0, 1) == 1;
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
